// File: rtl/mysystem_led_driver_pkg.sv
// -----------------------------------------------------------------------------
// mysystem_led_driver_pkg
// Purpose : Shared definitions for the LED driver slice. This package holds the
//           control-byte field layout, the FSM state encoding and the duty code
//           that forces the LEDs fully on.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package mysystem_led_driver_pkg;

  // Control byte layout: [3:0] duty, [4] blink enable, [5] invert, [7:6] blink rate
  localparam int CTRL_W       = 8;
  localparam int DUTY_MSB     = 3;
  localparam int DUTY_LSB     = 0;
  localparam int BLINK_EN_BIT = 4;
  localparam int INVERT_BIT   = 5;
  localparam int RATE_MSB     = 7;
  localparam int RATE_LSB     = 6;

  // Duty code that bypasses the phase comparison and keeps the LEDs solidly on
  localparam logic [3:0] DUTY_FULL = 4'hF;

  typedef enum logic {
    LAMP_TEST = 1'b0,
    RUN       = 1'b1
  } led_state_e;

endpackage

// File: rtl/mysystem_led_driver_if.sv
// -----------------------------------------------------------------------------
// mysystem_led_driver_if
// Purpose : Groups the PIO-facing pattern/control inputs and the pin-side
//           outputs of the LED driver.
// Signals : pattern_in       - LED pattern word, 1 = lit
//           ctrl_in          - control byte (duty/blink/invert/rate)
//           led_out          - registered pin drive
//           period_tick      - one-clk pulse per PWM period
//           lamp_test_active - high during the power-on lamp test
// Modports: master - PIO side (drives pattern/ctrl, observes outputs)
//           slave  - the LED driver itself
// -----------------------------------------------------------------------------
interface mysystem_led_driver_if
  import mysystem_led_driver_pkg::*;
#(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0]  pattern_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [WIDTH-1:0]  led_out;
  logic              period_tick;
  logic              lamp_test_active;

  modport master (
    output pattern_in, ctrl_in,
    input  led_out, period_tick, lamp_test_active
  );

  modport slave (
    input  pattern_in, ctrl_in,
    output led_out, period_tick, lamp_test_active
  );
endinterface

// File: rtl/mysystem_led_pwm_timebase.sv
// -----------------------------------------------------------------------------
// mysystem_led_pwm_timebase
// Purpose : PWM timebase. A prescaler produces a phase step every PWM_DIV
//           clocks, and a 4-bit phase counter sweeps 0..15. wrap_o marks the
//           last clock of a PWM period. period_tick_o is that wrap delayed by
//           one register stage.
// Ports   : clk           - system clock
//           reset_n       - asynchronous active-low reset
//           phase_o       - current PWM phase (0..15)
//           wrap_o        - combinational, high on the final clk of a period
//           period_tick_o - registered wrap (high the clk after wrap)
// -----------------------------------------------------------------------------
module mysystem_led_pwm_timebase #(
  parameter int PWM_DIV = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [3:0] phase_o,
  output logic       wrap_o,
  output logic       period_tick_o
);

  // The prescaler still needs one bit when PWM_DIV=1, even though it then stays at zero
  localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       phase_q, phase_d;
  logic             period_tick_q;
  logic             step;
  logic             wrap;

  always_comb begin
    step      = (div_cnt_q == DIV_W'(PWM_DIV - 1));
    wrap      = step && (phase_q == 4'hF);
    div_cnt_d = step ? '0 : div_cnt_q + 1'b1;
    phase_d   = step ? phase_q + 4'd1 : phase_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q     <= '0;
      phase_q       <= '0;
      period_tick_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      phase_q       <= phase_d;
      period_tick_q <= wrap;
    end
  end

  assign phase_o       = phase_q;
  assign wrap_o        = wrap;
  assign period_tick_o = period_tick_q;

endmodule

// File: rtl/mysystem_led_driver.sv
// -----------------------------------------------------------------------------
// mysystem_led_driver
// Purpose : Drives the LEDR pins from the LED PIO word. It applies a global
//           16-level PWM brightness, optional blink gating and output
//           inversion. After reset it runs a lamp test with all LEDs on for
//           LAMP_TEST_PERIODS PWM periods.
// Ports   : clk     - system clock (shared with the PIOs, so no synchronisers)
//           reset_n - asynchronous active-low reset
//           bus     - slave modport: pattern_in, ctrl_in in;
//                     led_out, period_tick, lamp_test_active out
// -----------------------------------------------------------------------------
module mysystem_led_driver
  import mysystem_led_driver_pkg::*;
#(
  parameter int WIDTH             = 10,
  parameter int PWM_DIV           = 50,
  parameter int LAMP_TEST_PERIODS = 31250,
  parameter int BLINK_LSB         = 13
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mysystem_led_driver_if.slave bus
);

  localparam int BLINK_W = BLINK_LSB + 4;
  localparam int IDX_W   = $clog2(BLINK_W);

  logic [WIDTH-1:0]   pattern_q;
  logic [CTRL_W-1:0]  ctrl_q;
  logic [3:0]         duty_q, duty_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [15:0]        lt_cnt_q;
  led_state_e         state_q;
  logic [WIDTH-1:0]   led_q;
  logic               lamp_q;

  logic [3:0]         phase;
  logic               wrap;
  logic               period_tick;
  logic               pwm_on;
  logic [IDX_W-1:0]   blink_idx;
  logic               blink_hide;
  logic [WIDTH-1:0]   run_led;

  mysystem_led_pwm_timebase #(
    .PWM_DIV (PWM_DIV)
  ) u_timebase (
    .clk           (clk),
    .reset_n       (reset_n),
    .phase_o       (phase),
    .wrap_o        (wrap),
    .period_tick_o (period_tick)
  );

  // Input stage: one register of latency on both PIO words
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= '0;
      ctrl_q    <= '0;
    end else begin
      pattern_q <= bus.pattern_in;
      ctrl_q    <= bus.ctrl_in;
    end
  end

  // Duty is only resampled at a period boundary. This keeps a mid-period change
  // from shortening or stretching the current on-time. The blink counter is
  // also advanced once per period.
  always_comb begin
    duty_d      = wrap ? ctrl_q[DUTY_MSB:DUTY_LSB] : duty_q;
    blink_cnt_d = wrap ? blink_cnt_q + 1'b1 : blink_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q      <= '0;
      blink_cnt_q <= '0;
    end else begin
      duty_q      <= duty_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  // Output gating. Each step up in rate selects the next blink counter bit,
  // which halves the blink frequency. Blink enable and rate act without waiting
  // for a period boundary. Inversion is applied last, so LEDs that are gated off
  // read as ones when invert is set.
  always_comb begin
    pwm_on     = (duty_q == DUTY_FULL) || (phase < duty_q);
    blink_idx  = IDX_W'(BLINK_LSB) + IDX_W'(ctrl_q[RATE_MSB:RATE_LSB]);
    blink_hide = ctrl_q[BLINK_EN_BIT] & blink_cnt_q[blink_idx];
    run_led    = (pattern_q & {WIDTH{pwm_on & ~blink_hide}})
               ^ {WIDTH{ctrl_q[INVERT_BIT]}};
  end

  // Lamp-test / run FSM with registered outputs. The LAMP_TEST->RUN step
  // happens on a wrap, and the first RUN value reaches led_out one clk later.
  // By then duty_q has already taken the value sampled on that same wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= LAMP_TEST;
      lt_cnt_q <= '0;
      led_q    <= '0;
      lamp_q   <= 1'b1;
    end else begin
      case (state_q)
        LAMP_TEST: begin
          led_q  <= '1;
          lamp_q <= 1'b1;
          if (wrap) begin
            if (lt_cnt_q == 16'(LAMP_TEST_PERIODS - 1)) begin
              state_q  <= RUN;
              lt_cnt_q <= '0;
            end else begin
              lt_cnt_q <= lt_cnt_q + 16'd1;
            end
          end
        end
        RUN: begin
          led_q  <= run_led;
          lamp_q <= 1'b0;
        end
        default: begin
          state_q <= LAMP_TEST;
          led_q   <= '1;
          lamp_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.led_out          = led_q;
  assign bus.period_tick      = period_tick;
  assign bus.lamp_test_active = lamp_q;

endmodule

// File: doc/mysystem_led_driver.md
Name: mysystem_led_driver

Overview:
- Downstream consumer of the 10-bit LED PIO output word; drives the physical LEDR pins.
- Adds a global 16-level PWM brightness, optional blink gating and output inversion.
- Runs a power-on lamp test, all LEDs full on, before normal pattern display.
- Control byte comes from a second PIO. Single clock domain with the PIOs, so no synchronisers are needed.

Parameters:
- WIDTH, 10, number of LEDs driven.
- PWM_DIV, 50, clk cycles per PWM phase step (>=1). One PWM period = 16*PWM_DIV clks.
- LAMP_TEST_PERIODS, 31250, number of PWM periods spent in lamp test after reset (>=1; 16-bit counter).
- BLINK_LSB, 13, blink counter bit used for rate 0. Counter width is BLINK_LSB+4.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pattern_in  in  WIDTH  LED pattern from PIO out_port; 1 = LED lit
- ctrl_in  in  8  [3:0] duty, [4] blink_en, [5] invert, [7:6] blink_rate
- led_out  out  WIDTH  registered pin drive
- period_tick  out  1  one-clk pulse on each PWM period wrap
- lamp_test_active  out  1  high while in LAMP_TEST state

Behaviour:
- Reset (async assert, sync release via flops on clk):
  - led_out=0, period_tick=0, lamp_test_active=1.
  - All counters=0; duty_q=0; input registers=0; state=LAMP_TEST.
- Input stage: pattern_q and ctrl_q register pattern_in and ctrl_in every clk, giving 1 cycle of latency.
- Prescaler:
  - div_cnt counts 0..PWM_DIV-1 and wraps.
  - step = (div_cnt==PWM_DIV-1). PWM_DIV=1 gives step every clk.
- Phase counter:
  - 4-bit phase increments on step, wrapping 15->0.
  - wrap = step && phase==15.
  - period_tick is registered wrap, so it is high the clk after wrap.
- Duty update:
  - duty_q <= ctrl_q[3:0] only on wrap, so a mid-period duty change never glitches the current period.
- PWM gate: pwm_on = (duty_q==15) || (phase < duty_q).
  - duty 0 = always off.
  - duty 15 = always on.
  - duty d (1..14) = on for d of 16 phases.
- Blink counter:
  - blink_cnt (BLINK_LSB+4 bits) increments on wrap and wraps freely at all-ones.
  - blink_hide = ctrl_q[4] && blink_cnt[BLINK_LSB+ctrl_q[7:6]].
  - Rate 0 is fastest; each step up halves the rate.
  - blink_en and rate take effect immediately; they are not period-aligned.
- State machine, 2 states:
  - LAMP_TEST:
    - led_out <= all ones, ignoring pattern, duty, blink and invert.
    - lt_cnt increments on wrap.
    - On the wrap where lt_cnt==LAMP_TEST_PERIODS-1, go to RUN and clear lt_cnt.
    - lamp_test_active is registered and falls with the first RUN-driven led_out.
  - RUN:
    - led_out <= (pattern_q & {WIDTH{pwm_on & ~blink_hide}}) ^ {WIDTH{ctrl_q[5]}}.
    - Invert applies after gating, so gated-off LEDs read all ones when inverted.
    - There is no exit from RUN except reset.
- Latency in RUN with pwm_on=1, blink off: pattern_in change to led_out = 2 clks. ctrl_in invert change to led_out = 2 clks.
- Simultaneous events: wrap and the LAMP_TEST->RUN transition in the same clk. The RUN equation applies from the next clk, using the already-updated duty_q.
- Reset mid-operation: everything returns to LAMP_TEST with counters cleared. A full lamp test repeats.

Decomposition:
- Shared package holds:
  - ctrl_in field positions and widths: DUTY_MSB/LSB=3/0, BLINK_EN_BIT=4, INVERT_BIT=5, RATE_MSB/LSB=7/6.
  - State encoding: LAMP_TEST=1'b0, RUN=1'b1.
  - DUTY_FULL=4'hF.
- One natural sub-module: mysystem_led_pwm_timebase. It owns the prescaler, phase counter, wrap and period_tick, and outputs phase and wrap.
- Gating, blink and the FSM stay in the top.

Test Plan:
Bench parameters: PWM_DIV=2, LAMP_TEST_PERIODS=2, BLINK_LSB=1. One PWM period = 32 clks.
1. Release reset, pattern_in=10'h155 -> led_out=10'h3FF and lamp_test_active=1 for ~64 clks. Then led_out follows 10'h155 gated by duty.
2. RUN, ctrl_in=8'h0F, change pattern_in 10'h155->10'h2AA -> led_out=10'h2AA exactly 2 clks later, steady. ctrl_in=8'h00 -> led_out=0 in every clk.
3. RUN, ctrl_in=8'h04, pattern=10'h3FF -> per 32-clk period, led_out=10'h3FF for 8 clks (phases 0-3), 0 for 24. period_tick pulses once per 32 clks.
4. Change duty 4->12 mid-period -> the current period keeps 8 on-clks. The next period after wrap has 24 on-clks.
5. ctrl_in=8'h1F (blink rate 0), pattern=10'h001 -> led_out bit0 alternates 2 periods on, 2 periods off. ctrl_in=8'h5F (rate 1) -> 4 on, 4 off.
6. ctrl_in=8'h20, pattern=10'h00F -> led_out=10'h3FF (duty 0, inverted). Assert reset_n=0 mid-RUN -> led_out=0 immediately, then a full lamp test repeats after release.
